pcihellocore_botoes_ctrl: RTL and testbench



---
 rtl/pcihellocore_botoes_ctrl_pkg.sv | 15 +
 rtl/pcihellocore_botoes_ctrl_if.sv | 20 ++
 rtl/pcihellocore_botoes_ctrl_debounce.sv | 59 +++++
 rtl/pcihellocore_botoes_ctrl.sv | 117 +++++++++++
 tb/tb_pcihellocore_botoes_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/pcihellocore_botoes_ctrl_pkg.sv
// Shared constants for the push-button controller: register map and edge-type encodings.
package pcihellocore_botoes_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_RAW  = 2'd1,
        ADDR_MASK = 2'd2,
        ADDR_EDGE = 2'd3
    } botoes_addr_e;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/pcihellocore_botoes_ctrl_if.sv
// Avalon-MM slave bundle for the push-button controller register window.
interface pcihellocore_botoes_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/pcihellocore_botoes_ctrl_debounce.sv
// One button line: two-flop synchroniser, tick-paced stability counter and debounced level.
module pcihellocore_botoes_debounce #(
    parameter int   DB_COUNT  = 4,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic raw_i,
    output logic sync_o,
    output logic db_o,
    output logic dbNext_o
);

    localparam int            CW       = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

    logic          meta_q;
    logic          sync_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A bounce back to the settled level clears the count, so only an unbroken run is accepted.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (tick_i) begin
            if (sync_q == db_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                db_d  = sync_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            db_q   <= RESET_VAL;
            cnt_q  <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sync_o   = sync_q;
    assign db_o     = db_q;
    assign dbNext_o = db_d;

endmodule

// File: rtl/pcihellocore_botoes_ctrl.sv
// Push-button debounce/event controller with a 4-word Avalon-MM register window.
// Optional interrupt mask and irq output are built only when BOTOES_CTRL_IRQ_EN is defined.
module pcihellocore_botoes_ctrl
    import pcihellocore_botoes_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               TICK_DIV  = 50000,
    parameter int               DB_COUNT  = 4,
    parameter int               EDGE_TYPE = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic                       clk,
    input  logic                       reset,
    pcihellocore_botoes_ctrl_if.slave  bus,
    input  logic [WIDTH-1:0]           in_port,
    output logic                       irq
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic             tick;
    logic [WIDTH-1:0] syncVal;
    logic [WIDTH-1:0] dbVal;
    logic [WIDTH-1:0] dbNext;
    logic [WIDTH-1:0] edgeSet;
    logic [WIDTH-1:0] edgeClr;
    logic [WIDTH-1:0] edgeCap_q;
    logic [WIDTH-1:0] edgeCap_d;
    logic [WIDTH-1:0] maskRead;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wrEn;

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;
    assign wrEn    = bus.chipselect && !bus.write_n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pcihellocore_botoes_debounce #(
            .DB_COUNT  (DB_COUNT),
            .RESET_VAL (RESET_VAL[i])
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .tick_i   (tick),
            .raw_i    (in_port[i]),
            .sync_o   (syncVal[i]),
            .db_o     (dbVal[i]),
            .dbNext_o (dbNext[i])
        );
    end

    // Edges are taken from the debounced next-state so capture lands on the same clock edge.
    always_comb begin
        edgeSet = '0;
        case (EDGE_TYPE)
            EDGE_RISING:  edgeSet = ~dbVal & dbNext;
            EDGE_FALLING: edgeSet = dbVal & ~dbNext;
            default:      edgeSet = dbVal ^ dbNext;
        endcase
    end

    assign edgeClr   = (wrEn && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
    assign edgeCap_d = (edgeCap_q & ~edgeClr) | edgeSet;

`ifdef BOTOES_CTRL_IRQ_EN
    logic [WIDTH-1:0] irqMask_q;
    logic [WIDTH-1:0] irqMask_d;
    logic             irq_q;

    assign irqMask_d = (wrEn && bus.address == ADDR_MASK) ? bus.writedata[WIDTH-1:0] : irqMask_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irqMask_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            irqMask_q <= irqMask_d;
            irq_q     <= |(edgeCap_q & irqMask_q);
        end
    end

    assign maskRead = irqMask_q;
    assign irq      = irq_q;
`else
    assign maskRead = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        readdata_d = '0;
        case (botoes_addr_e'(bus.address))
            ADDR_DATA: readdata_d = 32'(dbVal);
            ADDR_RAW:  readdata_d = 32'(syncVal);
            ADDR_MASK: readdata_d = 32'(maskRead);
            ADDR_EDGE: readdata_d = 32'(edgeCap_q);
            default:   readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= '0;
            edgeCap_q  <= '0;
            readdata_q <= '0;
        end else begin
            presc_q    <= presc_d;
            edgeCap_q  <= edgeCap_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_pcihellocore_botoes_ctrl.sv
// Self-checking bench for pcihellocore_botoes_ctrl: register table plus timed press/bounce/irq/collision sequences.
module tb_pcihellocore_botoes_ctrl;

    localparam int WIDTH    = 4;
    localparam int TICK_DIV = 4;
    localparam int DB_COUNT = 3;

`ifdef BOTOES_CTRL_IRQ_EN
    localparam logic        IRQ_EN  = 1'b1;
    localparam logic [31:0] MASK_WR = 32'h1;
`else
    localparam logic        IRQ_EN  = 1'b0;
    localparam logic [31:0] MASK_WR = 32'hF;
`endif

    typedef struct {
        logic        doWrite;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRead;
        string       name;
    } vec_t;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_port;
    logic             irq;
    int               cyc;
    int               checks;
    int               errors;

    pcihellocore_botoes_ctrl_if bus ();

    pcihellocore_botoes_ctrl #(
        .WIDTH     (WIDTH),
        .TICK_DIV  (TICK_DIV),
        .DB_COUNT  (DB_COUNT),
        .EDGE_TYPE (1),
        .RESET_VAL (4'hF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles since reset release; the prescaler ticks on every edge where this becomes a multiple of 4.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        bus.address = addr;
        @(negedge clk);
        data = bus.readdata;
    endtask

    task automatic alignTick();
        for (int k = 0; k < 8 && (cyc % TICK_DIV) != 0; k++) @(negedge clk);
    endtask

    vec_t        vecs[9];
    logic [31:0] rd;
    int          lat;

    initial begin
        vecs[0] = '{1'b0, 2'd0, 32'h0,        32'hF,                    "rst_data"};
        vecs[1] = '{1'b0, 2'd1, 32'h0,        32'hF,                    "rst_raw"};
        vecs[2] = '{1'b0, 2'd2, 32'h0,        32'h0,                    "rst_mask"};
        vecs[3] = '{1'b0, 2'd3, 32'h0,        32'h0,                    "rst_edge"};
        vecs[4] = '{1'b1, 2'd0, 32'h5,        32'hF,                    "ro_data_write"};
        vecs[5] = '{1'b1, 2'd1, 32'h0,        32'hF,                    "ro_raw_write"};
        vecs[6] = '{1'b1, 2'd2, 32'hFFFFFFFA, IRQ_EN ? 32'hA : 32'h0,   "mask_write"};
        vecs[7] = '{1'b1, 2'd2, 32'h0,        32'h0,                    "mask_clear"};
        vecs[8] = '{1'b1, 2'd3, 32'hF,        32'h0,                    "w1c_idle"};

        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        in_port        = 4'hF;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;

        repeat (3) @(negedge clk);
        checkOutput("rst_readdata", bus.readdata, 32'h0);
        checkOutput("rst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].doWrite) applyStimulus(vecs[v].addr, vecs[v].wdata);
            readReg(vecs[v].addr, rd);
            checkOutput(vecs[v].name, rd, vecs[v].expRead);
        end

        // Clean press of bit 0, polled through the data register.
        in_port[0]  = 1'b0;
        bus.address = 2'd0;
        lat         = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (!bus.readdata[0]) begin
                lat = c;
                break;
            end
        end
        checkOutput("press_latency_ok", {31'h0, (lat > 0 && lat <= 19)}, 32'h1);
        readReg(2'd3, rd);
        checkOutput("press_edge", rd, 32'h1);
        readReg(2'd1, rd);
        checkOutput("press_raw", rd, 32'hE);
        checkOutput("press_irq_masked", {31'h0, irq}, 32'h0);

        // Bounce on bit 1 with a half-period too short to satisfy the debounce run.
        for (int k = 0; k < 8; k++) begin
            in_port[1] = k[0];
            repeat (5) @(negedge clk);
        end
        in_port[1] = 1'b1;
        repeat (20) @(negedge clk);
        readReg(2'd0, rd);
        checkOutput("bounce_data", rd, 32'hE);
        readReg(2'd3, rd);
        checkOutput("bounce_edge", rd, 32'h1);

        // Release bit 0: a rising edge must not be captured.
        in_port[0] = 1'b1;
        repeat (20) @(negedge clk);
        readReg(2'd0, rd);
        checkOutput("release_data", rd, 32'hF);
        readReg(2'd3, rd);
        checkOutput("release_no_edge", rd, 32'h1);
        applyStimulus(2'd3, 32'hF);
        readReg(2'd3, rd);
        checkOutput("w1c_clear", rd, 32'h0);

        // Tick-aligned press of bit 0: db falls exactly 12 edges later, irq one edge after that.
        applyStimulus(2'd2, MASK_WR);
        alignTick();
        in_port[0] = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("irq_before_capture", {31'h0, irq}, 32'h0);
        @(negedge clk);
        checkOutput("irq_after_capture", {31'h0, irq}, {31'h0, IRQ_EN});
        readReg(2'd3, rd);
        checkOutput("irq_edge", rd, 32'h1);
        readReg(2'd2, rd);
        checkOutput("irq_mask_read", rd, IRQ_EN ? 32'h1 : 32'h0);
        applyStimulus(2'd3, 32'h1);
        checkOutput("irq_hold_on_clear", {31'h0, irq}, {31'h0, IRQ_EN});
        @(negedge clk);
        checkOutput("irq_fall", {31'h0, irq}, 32'h0);

        // W1C of bit 2 on the very edge its falling debounce is captured: set must win.
        alignTick();
        in_port[2] = 1'b0;
        repeat (11) @(negedge clk);
        bus.address    = 2'd3;
        bus.writedata  = 32'h4;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(negedge clk);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        readReg(2'd3, rd);
        checkOutput("collision_set_wins", rd, 32'h4);
        applyStimulus(2'd3, 32'h4);
        readReg(2'd3, rd);
        checkOutput("collision_cleared", rd, 32'h0);
        readReg(2'd0, rd);
        checkOutput("final_data", rd, 32'hA);
        checkOutput("final_irq", {31'h0, irq}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
